fp_round128_sched: RTL and testbench
====================================

# fp_round128_sched

Shared-resource scheduler for the 128-bit combinational rounding unit. Up to NREQ functional units (add, mul, div, sqrt, ...) present unrounded FP128N intermediates; the block arbitrates round-robin, registers the winner, rounds it and returns a registered FP128 result tagged with requester id and caller tag. It sits between the arithmetic cores and the FPU writeback/result bus and lets one rounding instance serve the whole FPU.

## Interface
- NREQ, 4: number of requesters (2..8)
- TAGW, 4: width of caller tag passed through unchanged
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- frm  in  3  dynamic rounding mode (CSR); used when a request carries rm=3'b111
- req_valid  in  NREQ  per-requester request strobe
- req_ready  out  NREQ  per-requester accept; transfer when valid&ready
- req_rm  in  3*NREQ  per-requester rounding mode (0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM, 7 dynamic)
- req_tag  in  TAGW*NREQ  per-requester tag
- req_data  in  131*NREQ  per-requester FP128N intermediate {sign, exp[14:0], mant[114:0]}, low bits [3:0] = l,g,r,s
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  128  rounded FP128 {sign, exp[14:0], frac[111:0]}
- out_id  out  $clog2(NREQ)  index of requester that produced out_data
- out_tag  out  TAGW  tag of that request
- out_nx  out  1  inexact flag
- out_of  out  1  overflow flag

## Operation
- Two registered stages: S1 (granted request: data, resolved rm, id, tag, valid) and S2 (rounded result, flags, id, tag, valid).
- Arbitration: round-robin over req_valid starting at ptr; lowest index at/after ptr wins, wrapping. ptr <- winner+1 (mod NREQ) only on an accepted transfer; unchanged otherwise.
- req_ready is one-hot or zero: asserted only for the winner, and only when S1 can load (stall = 0). A requester must hold valid/rm/tag/data until ready.
- stall = S2.valid & ~out_ready. When stall: S1 and S2 hold; no grant. When S1 empty or moving to S2, S1 loads the winner (or clears valid if none).
- rm resolution at S1 load: rm=7 -> frm sampled that cycle; rm 5,6 -> treated as RTZ.
- Rounding of S1 contents (combinational between S1 and S2): NaN/Inf input (exp all ones) not rounded. rnd per mode: RNE g&(r|s) | l&g&~r&~s; RTZ 0; RUP g&~sign; RDN g&sign; RMM g. Mantissa +rnd at bit 3; carry out of hidden bit increments exponent; denormal becoming normal sets hidden bit into exponent; result exponent reaching all ones forces fraction 0 (infinity).
- out_nx = (g|r|s) & exp!=all-ones, or overflow. out_of = result exponent all ones & input exponent not all ones.
- Sign passes through unmodified.

## Timing
- Reset (rst_n low, async): S1.valid=0, S2.valid=0, ptr=0, req_ready=0, out_valid=0, out_data=0, out_id=0, out_tag=0, out_nx=0, out_of=0. Release mid-transfer drops in-flight requests; requesters must retry.
- Latency: accept in cycle N -> out_valid in cycle N+2 (S1 at N+1, S2 at N+2).
- Throughput: one result per cycle with out_ready held high.
- Backpressure: out_data/out_id/out_tag/flags stable while out_valid & ~out_ready; no result dropped or duplicated.
- Simultaneous: out_ready rising in the same cycle S1 holds data -> S2 takes S1 and S1 takes new winner same edge.
- frm change takes effect only for requests accepted after the change.

## Test plan
- Single requester 0, rm=0, low nibble 4'b0100 (tie, l=0) -> fraction unchanged, out_nx=1, out_id=0, out_valid 2 cycles after accept; repeat with 4'b1100 -> fraction LSB +1.
- All four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle; out_id sequence matches; tags preserved.
- Max finite mantissa all ones, exp 0x7FFE, g=1, rm=2, sign 0 -> out_data 0x7FFF_0000..0 (+Inf), out_of=1, out_nx=1; same with rm=1 -> no change, out_of=0.
- Input NaN (exp 0x7FFF, nonzero mant, g=1), rm=0 -> exponent stays 0x7FFF, no increment, out_nx=0.
- out_ready low 5 cycles with req0, req1 pending -> out_valid held, outputs stable, req_ready all 0 after pipeline fills; release -> both results delivered in order, none lost.
- rm=7 with frm=3 and negative input, g=1 -> rounds toward -Inf (magnitude +1 LSB); assert rst_n low mid-stream -> out_valid, req_ready drop to 0 immediately.

Source files
------------

// File: rtl/fp_round128_sched.sv
// fp_round128_sched
//   Round-robin scheduler in front of a single 128-bit rounding unit.
//   Requesters present unrounded FP128N intermediates; the winner is
//   registered (S1), rounded combinationally, and the FP128 result is
//   registered (S2) together with the requester id and caller tag.
//
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   frm          dynamic rounding mode, used by requests carrying rm=7
//   req_valid    per-requester request strobe
//   req_ready    per-requester accept (one-hot or zero)
//   req_rm       per-requester rounding mode, 3 bits each
//   req_tag      per-requester caller tag, TAGW bits each
//   req_data     per-requester {sign, exp[14:0], frac[111:0], g, r, s}
//   out_valid    result valid
//   out_ready    downstream accept
//   out_data     rounded FP128 {sign, exp[14:0], frac[111:0]}
//   out_id       index of the requester that produced out_data
//   out_tag      caller tag of that request
//   out_nx       inexact flag
//   out_of       overflow flag
module fp_round128_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           frm,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_rm,
  input  logic [TAGW*NREQ-1:0] req_tag,
  input  logic [131*NREQ-1:0]  req_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [IDW-1:0]       out_id,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_nx,
  output logic                 out_of
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RUP = 3'd2,
    RM_RDN = 3'd3,
    RM_RMM = 3'd4,
    RM_DYN = 3'd7
  } rm_e;

  // Dynamic mode is replaced by frm at grant time; any encoding that is not
  // a concrete mode (5, 6, or an invalid frm) falls back to truncation.
  function automatic rm_e resolve_rm(input logic [2:0] rm, input logic [2:0] dyn);
    logic [2:0] m;
    m = (rm == RM_DYN) ? dyn : rm;
    case (m)
      3'd0:    return RM_RNE;
      3'd2:    return RM_RUP;
      3'd3:    return RM_RDN;
      3'd4:    return RM_RMM;
      default: return RM_RTZ;
    endcase
  endfunction

  // Unpacked views of the flat request buses
  logic [130:0]     data_a [NREQ];
  logic [2:0]       rm_a   [NREQ];
  logic [TAGW-1:0]  tag_a  [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_a[i] = req_data[i*131 +: 131];
      rm_a[i]   = req_rm[i*3 +: 3];
      tag_a[i]  = req_tag[i*TAGW +: TAGW];
    end
  end

  // Pipeline state
  logic [IDW-1:0]  ptr;
  logic            s1_valid;
  logic [130:0]    s1_data;
  rm_e             s1_rm;
  logic [IDW-1:0]  s1_id;
  logic [TAGW-1:0] s1_tag;
  logic            s2_valid;

  logic stall;
  assign stall     = s2_valid & ~out_ready;
  assign out_valid = s2_valid;

  // Round-robin pick: lowest valid index at/after ptr, else lowest below ptr.
  // Scanning downward lets the last hit in each half be the lowest index.
  logic           hi_found, lo_found, grant_any;
  logic [IDW-1:0] hi_idx, lo_idx, win;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req_valid[i-1]) begin
        if ((i - 1) >= 32'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i - 1);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i - 1);
        end
      end
    end
    grant_any = hi_found | lo_found;
    win       = hi_found ? hi_idx : lo_idx;
  end

  // Ready is gated by rst_n so it drops the moment reset asserts.
  logic accept;
  assign accept = grant_any & ~stall & rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Rounding of S1 contents. Adding the round bit to {0, frac} lets a carry
  // out of the fraction bump the exponent; for a denormal this is exactly
  // the step into the smallest normal exponent.
  logic         r_sign, r_l, r_g, r_r, r_s, r_special, rnd;
  logic [14:0]  r_exp, n_exp;
  logic [111:0] r_frac, n_frac;
  logic [112:0] sum;
  logic         n_nx, n_of;

  always_comb begin
    r_sign    = s1_data[130];
    r_exp     = s1_data[129:115];
    r_frac    = s1_data[114:3];
    r_l       = s1_data[3];
    r_g       = s1_data[2];
    r_r       = s1_data[1];
    r_s       = s1_data[0];
    r_special = &r_exp;

    case (s1_rm)
      RM_RNE:  rnd = (r_g & (r_r | r_s)) | (r_l & r_g & ~r_r & ~r_s);
      RM_RUP:  rnd = r_g & ~r_sign;
      RM_RDN:  rnd = r_g & r_sign;
      RM_RMM:  rnd = r_g;
      default: rnd = 1'b0;
    endcase

    sum    = {1'b0, r_frac} + {112'd0, rnd};
    n_exp  = r_exp + {14'd0, sum[112]};
    n_frac = sum[111:0];
    if (&n_exp) n_frac = '0;

    if (r_special) begin
      n_exp  = r_exp;
      n_frac = r_frac;
    end

    n_of = ~r_special & (&n_exp);
    n_nx = (~r_special & (r_g | r_r | r_s)) | n_of;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_rm    <= RM_RNE;
      s1_id    <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      out_tag  <= '0;
      out_nx   <= 1'b0;
      out_of   <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= {r_sign, n_exp, n_frac};
        out_id   <= s1_id;
        out_tag  <= s1_tag;
        out_nx   <= n_nx;
        out_of   <= n_of;
      end
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_data <= data_a[win];
        s1_rm   <= resolve_rm(rm_a[win], frm);
        s1_id   <= win;
        s1_tag  <= tag_a[win];
        ptr     <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_round128_sched.sv
// Testbench for fp_round128_sched: per-requester stimulus queues, a
// behavioural round-robin/pipeline-occupancy model, and a scoreboard of
// expected results consumed by an independent output monitor.
module tb_fp_round128_sched;

  localparam int NREQ = 4;
  localparam int TAGW = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           frm;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_rm;
  logic [TAGW*NREQ-1:0] req_tag;
  logic [131*NREQ-1:0]  req_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_data;
  logic [IDW-1:0]       out_id;
  logic [TAGW-1:0]      out_tag;
  logic                 out_nx;
  logic                 out_of;

  fp_round128_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n), .frm(frm),
    .req_valid(req_valid), .req_ready(req_ready), .req_rm(req_rm),
    .req_tag(req_tag), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_tag(out_tag), .out_nx(out_nx), .out_of(out_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
    logic [130:0]    data;
    bit              has_exp;
    logic [127:0]    edata;
    bit              enx;
    bit              eof;
  } req_t;

  typedef struct {
    logic [127:0]    data;
    logic [IDW-1:0]  id;
    logic [TAGW-1:0] tag;
    bit              nx;
    bit              of;
    int              acc;
    bit              seen;
  } exp_t;

  req_t  rq  [NREQ][$];
  req_t  act [NREQ];
  bit    act_v [NREQ];
  exp_t  sb [$];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int last_low = -1;
  bit go = 0;
  bit do_reset = 0;
  bit gap_en = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: follow rdy_hold
  bit rdy_hold = 1;

  // model state
  bit m1 = 0, m2 = 0;
  int ptr_m = 0;

  function automatic logic [130:0] mk(input bit s, input logic [14:0] e,
                                      input logic [111:0] f, input logic [2:0] grs);
    return {s, e, f, grs};
  endfunction

  // Rounding model: treat {exp, frac} as one unsigned magnitude and add the
  // increment decided from the guard/round/sticky value and the mode.
  function automatic exp_t ref_round(input logic [130:0] d, input logic [2:0] rm,
                                     input logic [2:0] f);
    exp_t r;
    int mode;
    logic [126:0] mag;
    logic [2:0] grs;
    bit inc, s;
    mode = (rm == 3'd7) ? int'(f) : int'(rm);
    if (mode > 4) mode = 1;
    s = d[130];
    grs = d[2:0];
    mag = d[129:3];
    r.id = '0; r.tag = '0; r.acc = 0; r.seen = 0;
    if (mag[126:112] == 15'h7FFF) begin
      r.data = {s, mag}; r.nx = 0; r.of = 0;
      return r;
    end
    case (mode)
      0: inc = (grs > 3'd4) || (grs == 3'd4 && mag[0]);
      2: inc = grs[2] && !s;
      3: inc = grs[2] && s;
      4: inc = grs[2];
      default: inc = 0;
    endcase
    mag = mag + 127'(inc);
    r.of = (mag[126:112] == 15'h7FFF);
    if (r.of) mag[111:0] = '0;
    r.nx = (grs != 3'd0) || r.of;
    r.data = {s, mag};
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    logic [127:0] t;
    logic [14:0] e;
    logic [111:0] f;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    f = t[111:0];
    if ($urandom_range(0, 3) == 0) f = '1;
    case ($urandom_range(0, 5))
      0: e = 15'h0000;
      1: e = 15'h7FFE;
      2: e = 15'h7FFF;
      default: e = 15'($urandom());
    endcase
    q.rm = 3'($urandom_range(0, 7));
    q.tag = TAGW'($urandom());
    q.data = mk(1'($urandom()), e, f, 3'($urandom()));
    q.has_exp = 0; q.edata = '0; q.enx = 0; q.eof = 0;
    return q;
  endfunction

  task automatic push_dir(input int idx, input logic [2:0] rm, input logic [TAGW-1:0] tag,
                          input logic [130:0] d, input logic [127:0] ed,
                          input bit enx, input bit eof);
    req_t q;
    q.rm = rm; q.tag = tag; q.data = d;
    q.has_exp = 1; q.edata = ed; q.enx = enx; q.eof = eof;
    rq[idx].push_back(q);
  endtask

  task automatic pack_ports();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = act_v[i];
      req_rm[i*3 +: 3] = act[i].rm;
      req_tag[i*TAGW +: TAGW] = act[i].tag;
      req_data[i*131 +: 131] = act[i].data;
    end
  endtask

  // Driver and pipeline/arbitration model
  initial begin : driver
    bit stall_m;
    int gnt;
    logic [NREQ-1:0] exp_rdy;
    bit done [NREQ];
    exp_t e;
    wait (go);
    forever begin
      @(negedge clk);
      stall_m = m2 && !out_ready;
      gnt = -1;
      if (!stall_m)
        for (int k = 0; k < NREQ; k++)
          if (gnt < 0 && act_v[(ptr_m + k) % NREQ]) gnt = (ptr_m + k) % NREQ;
      exp_rdy = '0;
      if (gnt >= 0) exp_rdy[gnt] = 1'b1;
      nchk++;
      if (req_ready !== exp_rdy) begin
        nerr++;
        $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
      end
      nchk++;
      if (out_valid !== m2) begin
        nerr++;
        $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, out_valid, m2);
      end
      for (int i = 0; i < NREQ; i++) done[i] = 0;
      if (gnt >= 0) begin
        if (act[gnt].has_exp) begin
          e.data = act[gnt].edata; e.nx = act[gnt].enx; e.of = act[gnt].eof;
        end else begin
          e = ref_round(act[gnt].data, act[gnt].rm, frm);
        end
        e.id = IDW'(gnt); e.tag = act[gnt].tag; e.acc = cyc; e.seen = 0;
        sb.push_back(e);
        ptr_m = (gnt + 1) % NREQ;
        done[gnt] = 1;
      end
      if (!stall_m) begin
        m2 = m1;
        m1 = (gnt >= 0);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (do_reset) begin
        rst_n = 1'b0;
        #1;
        nchk++;
        if (out_valid !== 1'b0 || req_ready !== '0 || out_data !== '0 || out_id !== '0 ||
            out_tag !== '0 || out_nx !== 1'b0 || out_of !== 1'b0) begin
          nerr++;
          $display("FAIL midreset: got valid=%b ready=%b data=%h expected all zero",
                   out_valid, req_ready, out_data);
        end
        sb.delete();
        m1 = 0; m2 = 0; ptr_m = 0;
        @(negedge clk);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        do_reset = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) act_v[i] = 0;
        if (!act_v[i] && rq[i].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
          act[i] = rq[i].pop_front();
          act_v[i] = 1;
        end
      end
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = rdy_hold;
      endcase
      if (!out_ready) last_low = cyc;
      pack_ports();
    end
  end

  // Output monitor: compares against the scoreboard head every cycle the
  // result is presented, so held results are checked for stability too.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_out cyc=%0d: got data=%h id=%0d with no result expected",
                   cyc, out_data, out_id);
        end else begin
          e = sb[0];
          if (out_data !== e.data || out_id !== e.id || out_tag !== e.tag ||
              out_nx !== e.nx || out_of !== e.of) begin
            nerr++;
            $display("FAIL result cyc=%0d: got data=%h id=%0d tag=%h nx=%b of=%b expected data=%h id=%0d tag=%h nx=%b of=%b",
                     cyc, out_data, out_id, out_tag, out_nx, out_of,
                     e.data, e.id, e.tag, e.nx, e.of);
          end
          if (!e.seen) begin
            sb[0].seen = 1;
            if (last_low < e.acc) begin
              nchk++;
              if (cyc != e.acc + 2) begin
                nerr++;
                $display("FAIL latency: got %0d cycles expected 2", cyc - e.acc);
              end
            end
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit busy;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #2;
      busy = m1 || m2 || (sb.size() != 0);
      for (int i = 0; i < NREQ; i++) busy = busy || act_v[i] || (rq[i].size() != 0);
      if (!busy) return;
    end
    nchk++;
    nerr++;
    $display("FAIL drain_timeout: got busy after %0d cycles expected idle", budget);
  endtask

  localparam logic [111:0] F0 = 112'h0123456789ABCDEF0123456789A0;
  localparam logic [111:0] F1 = 112'h0123456789ABCDEF0123456789A1;
  localparam logic [111:0] F2 = 112'h0123456789ABCDEF0123456789A2;

  initial begin : main
    for (int i = 0; i < NREQ; i++) begin
      act_v[i] = 0;
      act[i] = '{rm: '0, tag: '0, data: '0, has_exp: 0, edata: '0, enx: 0, eof: 0};
    end
    rst_n = 1'b0;
    frm = 3'd3;
    out_ready = 1'b1;
    pack_ports();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (out_valid !== 1'b0 || req_ready !== '0 || out_data !== '0 || out_id !== '0 ||
        out_tag !== '0 || out_nx !== 1'b0 || out_of !== 1'b0) begin
      nerr++;
      $display("FAIL reset: got valid=%b ready=%b data=%h id=%0d tag=%h nx=%b of=%b expected all zero",
               out_valid, req_ready, out_data, out_id, out_tag, out_nx, out_of);
    end
    rst_n = 1'b1;
    go = 1;

    // Directed rounding cases on requester 0
    push_dir(0, 3'd0, 4'h1, mk(0, 15'h3FFF, F0, 3'b100), {1'b0, 15'h3FFF, F0}, 1, 0);
    push_dir(0, 3'd0, 4'h2, mk(0, 15'h3FFF, F1, 3'b100), {1'b0, 15'h3FFF, F2}, 1, 0);
    push_dir(0, 3'd2, 4'h3, mk(0, 15'h7FFE, '1, 3'b100), {1'b0, 15'h7FFF, 112'd0}, 1, 1);
    push_dir(0, 3'd1, 4'h4, mk(0, 15'h7FFE, '1, 3'b100), {1'b0, 15'h7FFE, {112{1'b1}}}, 1, 0);
    push_dir(0, 3'd0, 4'h5, mk(0, 15'h7FFF, 112'h1, 3'b100), {1'b0, 15'h7FFF, 112'h1}, 0, 0);
    push_dir(0, 3'd7, 4'h6, mk(1, 15'h4000, F0, 3'b100), {1'b1, 15'h4000, F1}, 1, 0);
    wait_idle(200);

    // All requesters busy, downstream always ready
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 6; n++) rq[i].push_back(rand_req());
    wait_idle(300);

    // Backpressure with two requesters pending
    rdy_mode = 2;
    rdy_hold = 0;
    @(posedge clk);
    #2;
    for (int n = 0; n < 3; n++) begin
      rq[0].push_back(rand_req());
      rq[1].push_back(rand_req());
    end
    repeat (8) @(posedge clk);
    #2;
    rdy_hold = 1;
    wait_idle(200);

    // Random traffic, random backpressure, frm changes and a mid-stream reset
    rdy_mode = 1;
    gap_en = 1;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 40; n++) rq[i].push_back(rand_req());
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 4) == 0) frm = 3'($urandom_range(0, 7));
    end
    do_reset = 1;
    for (int n = 0; n < 20 && do_reset; n++) @(posedge clk);
    if (do_reset) begin
      nchk++;
      nerr++;
      $display("FAIL reset_handshake: got pending expected done");
    end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 4) == 0) frm = 3'($urandom_range(0, 7));
    end
    wait_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
